// File: rtl/vertex_adjacency_builder.sv
// Walks a face list in a source RAM and builds per-vertex neighbor lists
// (count word + neighbor slots) in a destination RAM, clearing counts first.
module vertex_adjacency_builder #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned FACE_VERTS = 4,
  parameter int unsigned MAX_VAL    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] face_base,
  input  logic [15:0]       face_count,
  input  logic [ADDR_W-1:0] vtx_base,
  input  logic [IDX_W:0]    vtx_count,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_do,
  output logic              dst_en,
  output logic [3:0]        dst_we,
  output logic [ADDR_W-1:0] dst_a,
  output logic [DATA_W-1:0] dst_di,
  input  logic [DATA_W-1:0] dst_do,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              err_idx
);

  localparam int unsigned S  = MAX_VAL + 1;
  localparam int unsigned KW = $clog2(FACE_VERTS + 1);
  localparam int unsigned EW = $clog2(FACE_VERTS);
  localparam int unsigned CW = $clog2(MAX_VAL + 1);

  typedef logic [IDX_W:0] vcnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FACE_RD,
    S_EDGE_RD,
    S_EDGE_CAP,
    S_EDGE_WN,
    S_EDGE_WC,
    S_DONE
  } state_t;

  state_t            state_q, state_d, edge_next;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [ADDR_W-1:0] vbase_q, vbase_d;
  vcnt_t             vcnt_q, vcnt_d;
  logic [15:0]       face_left_q, face_left_d;
  vcnt_t             clr_v_q, clr_v_d;
  logic [ADDR_W-1:0] clr_a_q, clr_a_d;
  logic [KW-1:0]     k_q, k_d;
  logic [EW-1:0]     e_q, e_d;
  logic [IDX_W-1:0]  verts_q [FACE_VERTS];
  logic [IDX_W-1:0]  verts_d [FACE_VERTS];
  logic [CW-1:0]     c_q, c_d;
  logic              ovf_q, ovf_d;
  logic              idx_q, idx_d;

  logic [IDX_W-1:0]  va, vb;
  logic              edge_bad, edge_deg, last_edge, cap_ovf, edge_adv;
  logic [ADDR_W-1:0] ra;
  logic              unused_src;

  assign unused_src = ^src_do[DATA_W-1:IDX_W];

  // Current directed edge a -> b, closing back to the first vertex of the face.
  always_comb begin
    va = '0;
    vb = '0;
    for (int unsigned i = 0; i < FACE_VERTS; i++) begin
      if (e_q == EW'(i)) begin
        va = verts_q[i];
        vb = verts_q[(i + 1) % FACE_VERTS];
      end
    end
  end

  assign edge_bad  = ({1'b0, va} >= vcnt_q) || ({1'b0, vb} >= vcnt_q);
  assign edge_deg  = (va == vb);
  assign last_edge = (e_q == EW'(FACE_VERTS - 1));
  assign cap_ovf   = (dst_do >= DATA_W'(MAX_VAL));
  assign ra        = vbase_q + ADDR_W'(va * S);

  always_comb begin
    if (!last_edge)               edge_next = S_EDGE_RD;
    else if (face_left_q == 16'd1) edge_next = S_DONE;
    else                           edge_next = S_FACE_RD;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vtx_count != '0)       state_d = S_CLEAR;
          else if (face_count != '0) state_d = S_FACE_RD;
          else                       state_d = S_DONE;
        end
      end
      S_CLEAR: begin
        if (clr_v_q + vcnt_t'(1) == vcnt_q)
          state_d = (face_left_q != '0) ? S_FACE_RD : S_DONE;
      end
      S_FACE_RD: begin
        if (k_q == KW'(FACE_VERTS)) state_d = S_EDGE_RD;
      end
      S_EDGE_RD: begin
        if (edge_bad || edge_deg) state_d = edge_next;
        else                      state_d = S_EDGE_CAP;
      end
      S_EDGE_CAP: state_d = cap_ovf ? edge_next : S_EDGE_WN;
      S_EDGE_WN:  state_d = S_EDGE_WC;
      S_EDGE_WC:  state_d = edge_next;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    err_ovf = ovf_q;
    err_idx = idx_q;
    src_en  = 1'b0;
    src_a   = '0;
    dst_en  = 1'b0;
    dst_we  = '0;
    dst_a   = '0;
    dst_di  = '0;
    case (state_q)
      S_CLEAR: begin
        dst_en = 1'b1;
        dst_we = '1;
        dst_a  = clr_a_q;
      end
      S_FACE_RD: begin
        if (k_q < KW'(FACE_VERTS)) begin
          src_en = 1'b1;
          src_a  = faddr_q;
        end
      end
      S_EDGE_RD: begin
        if (!edge_bad && !edge_deg) begin
          dst_en = 1'b1;
          dst_a  = ra;
        end
      end
      S_EDGE_WN: begin
        dst_en = 1'b1;
        dst_we = '1;
        dst_a  = ra + ADDR_W'(c_q) + ADDR_W'(1);
        dst_di = DATA_W'(vb);
      end
      S_EDGE_WC: begin
        dst_en = 1'b1;
        dst_we = '1;
        dst_a  = ra;
        dst_di = DATA_W'(c_q) + DATA_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    faddr_d     = faddr_q;
    vbase_d     = vbase_q;
    vcnt_d      = vcnt_q;
    face_left_d = face_left_q;
    clr_v_d     = clr_v_q;
    clr_a_d     = clr_a_q;
    k_d         = k_q;
    e_d         = e_q;
    verts_d     = verts_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    edge_adv    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          faddr_d     = face_base;
          vbase_d     = vtx_base;
          vcnt_d      = vtx_count;
          face_left_d = face_count;
          clr_v_d     = '0;
          clr_a_d     = vtx_base;
          k_d         = '0;
          e_d         = '0;
          ovf_d       = 1'b0;
          idx_d       = 1'b0;
        end
      end
      S_CLEAR: begin
        clr_v_d = clr_v_q + vcnt_t'(1);
        clr_a_d = clr_a_q + ADDR_W'(S);
      end
      S_FACE_RD: begin
        // Read k is captured one cycle later, hence the extra capture cycle.
        if (k_q < KW'(FACE_VERTS)) faddr_d = faddr_q + ADDR_W'(1);
        for (int unsigned i = 0; i < FACE_VERTS; i++) begin
          if (k_q == KW'(i + 1)) verts_d[i] = src_do[IDX_W-1:0];
        end
        k_d = (k_q == KW'(FACE_VERTS)) ? '0 : k_q + KW'(1);
      end
      S_EDGE_RD: begin
        if (edge_bad) idx_d = 1'b1;
        if (edge_bad || edge_deg) edge_adv = 1'b1;
      end
      S_EDGE_CAP: begin
        c_d = CW'(dst_do);
        if (cap_ovf) begin
          ovf_d    = 1'b1;
          edge_adv = 1'b1;
        end
      end
      S_EDGE_WC: edge_adv = 1'b1;
      default: ;
    endcase
    if (edge_adv) begin
      if (last_edge) begin
        e_d         = '0;
        face_left_d = face_left_q - 16'd1;
      end else begin
        e_d = e_q + EW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faddr_q     <= '0;
      vbase_q     <= '0;
      vcnt_q      <= '0;
      face_left_q <= '0;
      clr_v_q     <= '0;
      clr_a_q     <= '0;
      k_q         <= '0;
      e_q         <= '0;
      verts_q     <= '{default: '0};
      c_q         <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= 1'b0;
    end else begin
      faddr_q     <= faddr_d;
      vbase_q     <= vbase_d;
      vcnt_q      <= vcnt_d;
      face_left_q <= face_left_d;
      clr_v_q     <= clr_v_d;
      clr_a_q     <= clr_a_d;
      k_q         <= k_d;
      e_q         <= e_d;
      verts_q     <= verts_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_vertex_adjacency_builder.sv
// Bench for vertex_adjacency_builder: table of mesh scenarios plus randomized
// face lists checked against an edge-by-edge adjacency model.
module tb_vertex_adjacency_builder;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int FV = 4;
  localparam int MV = 7;
  localparam int S  = MV + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] face_base = '0;
  logic [15:0]   face_count = '0;
  logic [AW-1:0] vtx_base = '0;
  logic [IW:0]   vtx_count = '0;
  logic          src_en;
  logic [AW-1:0] src_a;
  logic [DW-1:0] src_do = '0;
  logic          dst_en;
  logic [3:0]    dst_we;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] dst_di;
  logic [DW-1:0] dst_do = '0;
  logic          busy, done, err_ovf, err_idx;

  vertex_adjacency_builder #(
    .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .FACE_VERTS(FV), .MAX_VAL(MV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .face_base(face_base), .face_count(face_count),
    .vtx_base(vtx_base), .vtx_count(vtx_count),
    .src_en(src_en), .src_a(src_a), .src_do(src_do),
    .dst_en(dst_en), .dst_we(dst_we), .dst_a(dst_a), .dst_di(dst_di), .dst_do(dst_do),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src_mem [0:511];
  logic [DW-1:0] dst_mem [0:511];
  int unsigned   wr_total = 0;

  always @(posedge clk) begin
    if (src_en) src_do <= src_mem[src_a];
    if (dst_en) begin
      if (dst_we != 4'h0) begin
        dst_mem[dst_a] = dst_di;
        wr_total++;
      end else begin
        dst_do <= dst_mem[dst_a];
      end
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] fvtx [0:255];
  int m_cnt [256];
  int m_nbr [256][8];

  typedef struct {
    logic [255:0] faces;
    int nf; int fb; int vb; int vc;
    int lat; bit ovf; bit idx; bit poke;
  } case_t;
  case_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Adjacency built directly from the edge rules, plus the cycle budget they imply.
  task automatic model(input int nf, input int vc, output int lat, output bit movf,
                       output bit midx, output int nwr);
    int ef, es, eo;
    ef = 0; es = 0; eo = 0; movf = 0; midx = 0;
    for (int v = 0; v < 256; v++) m_cnt[v] = 0;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < FV; k++) begin
        int a, b;
        a = int'(fvtx[f*FV + k]);
        b = int'(fvtx[f*FV + (k + 1) % FV]);
        if (a >= vc || b >= vc) begin midx = 1; es++; end
        else if (a == b) es++;
        else if (m_cnt[a] >= MV) begin movf = 1; eo++; end
        else begin m_nbr[a][m_cnt[a]] = b; m_cnt[a]++; ef++; end
      end
    end
    lat = 1 + vc + nf*(FV + 1) + 4*ef + es + 2*eo;
    nwr = vc + 2*ef;
  endtask

  task automatic run(input string tag, input int nf, input int fb, input int vb, input int vc,
                     input int exp_lat, input bit exp_ovf, input bit exp_idx, input bit poke);
    int mlat, nwr, cyc, base;
    int unsigned w0;
    bit movf, midx;
    logic [23:0] junk;
    model(nf, vc, mlat, movf, midx, nwr);
    if (exp_lat < 0) begin
      exp_lat = mlat; exp_ovf = movf; exp_idx = midx;
    end
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < FV; k++) begin
        junk = 24'($urandom);
        src_mem[AW'(fb + f*FV + k)] = {junk, fvtx[f*FV + k]};
      end
    for (int i = 0; i < 512; i++) dst_mem[i] = $urandom;
    @(negedge clk);
    w0 = wr_total;
    face_base = AW'(fb); vtx_base = AW'(vb); face_count = 16'(nf); vtx_count = (IW+1)'(vc);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    face_base = AW'($urandom); vtx_base = AW'($urandom);
    face_count = 16'($urandom); vtx_count = (IW+1)'($urandom);
    chk($sformatf("%s busy", tag), 64'(busy), 64'd1);
    while (!done && cyc < exp_lat + 50) begin
      start = poke && cyc >= 4 && cyc < 8;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("%s done seen", tag), 64'(done), 64'd1);
    chk($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
    chk($sformatf("%s flags", tag), 64'({err_ovf, err_idx}), 64'({exp_ovf, exp_idx}));
    @(negedge clk);
    chk($sformatf("%s idle after done", tag), 64'({done, busy}), 64'd0);
    chk($sformatf("%s sticky flags", tag), 64'({err_ovf, err_idx}), 64'({exp_ovf, exp_idx}));
    chk($sformatf("%s write count", tag), 64'(wr_total - w0), 64'(nwr));
    for (int v = 0; v < vc; v++) begin
      base = (vb + v*S) % 512;
      chk($sformatf("%s cnt[%0d]", tag, v), 64'(dst_mem[base]), 64'(m_cnt[v]));
      for (int j = 0; j < m_cnt[v]; j++)
        chk($sformatf("%s nbr[%0d][%0d]", tag, v, j),
            64'(dst_mem[(base + 1 + j) % 512]), 64'(m_nbr[v][j]));
    end
  endtask

  initial begin
    int vc, nf;
    tbl[0] = '{faces: 256'(32'h03020100), nf: 1, fb: 10, vb: 64, vc: 4,
               lat: 26, ovf: 0, idx: 0, poke: 0};
    tbl[1] = '{faces: 256'({32'h05060201, 32'h03070400, 32'h06070302,
                            32'h04050100, 32'h07060504, 32'h01020300}),
               nf: 6, fb: 500, vb: 0, vc: 8, lat: 135, ovf: 0, idx: 0, poke: 1};
    tbl[2] = '{faces: '0, nf: 8, fb: 0, vb: 480, vc: 20, lat: 185, ovf: 1, idx: 0, poke: 0};
    for (int q = 0; q < 8; q++)
      tbl[2].faces[q*32 +: 32] = {8'd19, 8'(q + 2), 8'(q + 1), 8'd0};
    tbl[3] = '{faces: 256'({32'h05040202, 32'h03090100}), nf: 2, fb: 100, vb: 200, vc: 8,
               lat: 42, ovf: 0, idx: 1, poke: 0};
    tbl[4] = '{faces: '0, nf: 0, fb: 0, vb: 33, vc: 5, lat: 6, ovf: 0, idx: 0, poke: 0};
    tbl[5] = '{faces: 256'(32'h03020100), nf: 1, fb: 300, vb: 16, vc: 0,
               lat: 10, ovf: 0, idx: 1, poke: 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'({busy, done, err_ovf, err_idx, src_en, dst_en, dst_we,
                              src_a, dst_a, dst_di}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 32; j++) fvtx[j] = tbl[i].faces[j*8 +: 8];
      run($sformatf("case%0d", i), tbl[i].nf, tbl[i].fb, tbl[i].vb, tbl[i].vc,
          tbl[i].lat, tbl[i].ovf, tbl[i].idx, tbl[i].poke);
    end

    // Abort mid-CLEAR with an asynchronous reset, then a full clean run.
    @(negedge clk);
    vtx_count = 9'd40; face_count = 16'd1; vtx_base = '0; face_base = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-clear active", 64'({busy, dst_en, dst_we}), 64'h3F);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, err_ovf, err_idx, src_en, dst_en, dst_we,
                                    src_a, dst_a, dst_di}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 32; j++) fvtx[j] = tbl[1].faces[j*8 +: 8];
    run("after reset", tbl[1].nf, tbl[1].fb, tbl[1].vb, tbl[1].vc,
        tbl[1].lat, tbl[1].ovf, tbl[1].idx, 1'b0);

    for (int r = 0; r < 8; r++) begin
      vc = $urandom_range(1, 40);
      nf = $urandom_range(0, 12);
      for (int j = 0; j < nf*FV; j++) begin
        if ($urandom_range(0, 9) == 0) fvtx[j] = 8'(vc + $urandom_range(0, 3));
        else                           fvtx[j] = 8'($urandom_range(0, vc - 1));
      end
      run($sformatf("rand%0d", r), nf, $urandom_range(0, 511), $urandom_range(0, 511), vc,
          -1, 1'b0, 1'b0, r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
